// File: rtl/instr_encoder.sv
// Instruction encoder: turns one request into opcode (+ optional immediate) bytes
// written sequentially into program memory. Optional build macro: INSTR_ENCODER_CHECK_EN.

`ifndef INSTR_ENCODER_SYMBOLS
`define INSTR_ENCODER_SYMBOLS
`define OP_NOP  8'h00
`define OP_HLT  8'h01
`define OP_CALL 8'h02
`define OP_RET  8'h03
`define OP_CMP  8'h04
`define OP_JMP  8'h05
`define OP_LDI  8'h08
`define OP_LDX  8'h10
`define OP_STX  8'h18
`define OP_PUSH 8'h20
`define OP_POP  8'h28
`define OP_ALU  8'h40
`define OP_MOV  8'h80
`endif

module instr_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_class,
    input  logic [2:0] req_dst,
    input  logic [2:0] req_src,
    input  logic [3:0] req_alu,
    input  logic       req_imm_en,
    input  logic [7:0] req_imm,
    input  logic       clear,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       full,
    output logic       error
);

    localparam logic [7:0] LpLdi  = `OP_LDI;
    localparam logic [7:0] LpLdx  = `OP_LDX;
    localparam logic [7:0] LpStx  = `OP_STX;
    localparam logic [7:0] LpPush = `OP_PUSH;
    localparam logic [7:0] LpPop  = `OP_POP;
    localparam logic [7:0] LpAlu  = `OP_ALU;
    localparam logic [7:0] LpMov  = `OP_MOV;

    typedef enum logic [1:0] {StIdle, StEmitOp, StEmitImm, StFull} state_e;

    state_e     r_state;
    logic       r_we;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_full;
    logic       r_error;
    logic       r_imm_en;
    logic [7:0] r_imm;
    logic [7:0] w_enc;

    always_comb begin
        w_enc = `OP_NOP;
        case (req_class)
            4'd0:    w_enc = `OP_NOP;
            4'd1:    w_enc = `OP_HLT;
            4'd2:    w_enc = `OP_CALL;
            4'd3:    w_enc = `OP_RET;
            4'd4:    w_enc = `OP_CMP;
            4'd5:    w_enc = {LpAlu[7:4], req_alu[3], req_alu[2:0]};
            4'd6:    w_enc = {LpLdi[7:3], req_src};
            4'd7:    w_enc = {LpLdx[7:3], req_src};
            4'd8:    w_enc = {LpStx[7:3], req_src};
            4'd9:    w_enc = {LpPush[7:3], req_src};
            4'd10:   w_enc = {LpPop[7:3], req_src};
            4'd11:   w_enc = `OP_JMP;
            4'd12:   w_enc = {LpMov[7:6], req_dst, req_src};
            default: w_enc = `OP_NOP;
        endcase
    end

    // Opcode byte is registered at acceptance so the write lands one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_we     <= 1'b0;
            r_addr   <= 8'h00;
            r_wdata  <= 8'h00;
            r_full   <= 1'b0;
            r_error  <= 1'b0;
            r_imm_en <= 1'b0;
            r_imm    <= 8'h00;
        end else if (clear) begin
            r_state <= StIdle;
            r_we    <= 1'b0;
            r_addr  <= 8'h00;
            r_full  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_we <= 1'b0;
                    if (req_valid) begin
`ifdef INSTR_ENCODER_CHECK_EN
                        if (req_class > 4'd12) begin
                            r_error <= 1'b1;
                        end else begin
                            r_we     <= 1'b1;
                            r_wdata  <= w_enc;
                            r_imm_en <= req_imm_en;
                            r_imm    <= req_imm;
                            r_state  <= StEmitOp;
                        end
`else
                        r_we     <= 1'b1;
                        r_wdata  <= w_enc;
                        r_imm_en <= req_imm_en;
                        r_imm    <= req_imm;
                        r_state  <= StEmitOp;
`endif
                    end
                end
                StEmitOp: begin
                    if (r_addr == 8'hFF) begin
                        // Opcode took the last slot: immediate has nowhere to go.
                        r_we    <= 1'b0;
                        r_full  <= 1'b1;
                        r_state <= StFull;
                        if (r_imm_en) r_error <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 8'd1;
                        if (r_imm_en) begin
                            r_we    <= 1'b1;
                            r_wdata <= r_imm;
                            r_state <= StEmitImm;
                        end else begin
                            r_we    <= 1'b0;
                            r_state <= StIdle;
                        end
                    end
                end
                StEmitImm: begin
                    r_we <= 1'b0;
                    if (r_addr == 8'hFF) begin
                        r_full  <= 1'b1;
                        r_state <= StFull;
                    end else begin
                        r_addr  <= r_addr + 8'd1;
                        r_state <= StIdle;
                    end
                end
                StFull: begin
                    r_we <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (r_state == StIdle);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign full      = r_full;
    assign error     = r_error;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: scoreboard of expected {addr,data} writes checked
// by a negedge monitor, plus immediate-assertion checks of status outputs.

module tb_instr_encoder;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_class;
    logic [2:0] req_dst;
    logic [2:0] req_src;
    logic [3:0] req_alu;
    logic       req_imm_en;
    logic [7:0] req_imm;
    logic       clear;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       full;
    logic       error;

    int vectors     = 0;
    int miscompares = 0;
    logic [15:0] sb[$];
    logic [7:0]  exp_addr;

    instr_encoder u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_class  (req_class),
        .req_dst    (req_dst),
        .req_src    (req_src),
        .req_alu    (req_alu),
        .req_imm_en (req_imm_en),
        .req_imm    (req_imm),
        .clear      (clear),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .full       (full),
        .error      (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference encoding with the opcode map written out literally.
    function automatic logic [7:0] enc(input logic [3:0] c, input logic [2:0] d,
                                       input logic [2:0] s, input logic [3:0] a);
        case (c)
            4'd0:    return 8'h00;
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h03;
            4'd4:    return 8'h04;
            4'd5:    return {4'b0100, a};
            4'd6:    return {5'b00001, s};
            4'd7:    return {5'b00010, s};
            4'd8:    return {5'b00011, s};
            4'd9:    return {5'b00100, s};
            4'd10:   return {5'b00101, s};
            4'd11:   return 8'h05;
            4'd12:   return {2'b10, d, s};
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [15:0] want;
        if (mem_we === 1'b1) begin
            want = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
            vectors++;
            assert ({mem_addr, mem_wdata} === want) else begin
                miscompares++;
                $error("FAIL mem_write observed=%h_%h required=%h", mem_addr, mem_wdata, want);
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h required=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        sb.push_back({a, d});
    endtask

    task automatic do_req(input logic [3:0] c, input logic [2:0] d, input logic [2:0] s,
                          input logic [3:0] a, input logic ie, input logic [7:0] im);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_ready", {15'd0, req_ready}, 16'd1);
        req_class  = c;
        req_dst    = d;
        req_src    = s;
        req_alu    = a;
        req_imm_en = ie;
        req_imm    = im;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        exp_addr = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        chk("rst_we",    {15'd0, mem_we}, 16'd0);
        chk("rst_addr",  {8'd0, mem_addr}, 16'd0);
        chk("rst_wdata", {8'd0, mem_wdata}, 16'd0);
        chk("rst_full",  {15'd0, full}, 16'd0);
        chk("rst_error", {15'd0, error}, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_addr = 8'h00;
        @(negedge clk);
        chk("rst_ready", {15'd0, req_ready}, 16'd1);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; req_valid = 1'b0; req_class = 4'd0; req_dst = 3'd0;
        req_src = 3'd0; req_alu = 4'd0; req_imm_en = 1'b0; req_imm = 8'h00;
        exp_addr = 8'h00;
        do_reset();

        // MOV dst=3 src=5
        expect_wr(8'h00, 8'h9D);
        do_req(4'd12, 3'd3, 3'd5, 4'd0, 1'b0, 8'h00);
        idle(2);
        chk("mov_addr_after", {8'd0, mem_addr}, 16'd1);

        // LDI src=2 imm=A5, ready low for two cycles
        expect_wr(8'h01, 8'h0A);
        expect_wr(8'h02, 8'hA5);
        do_req(4'd6, 3'd0, 3'd2, 4'd0, 1'b1, 8'hA5);
        @(negedge clk); chk("ldi_ready_c1", {15'd0, req_ready}, 16'd0);
        @(negedge clk); chk("ldi_ready_c2", {15'd0, req_ready}, 16'd0);
        @(negedge clk); chk("ldi_ready_c3", {15'd0, req_ready}, 16'd1);
        chk("ldi_wdata_hold", {8'd0, mem_wdata}, 16'h00A5);

        // ALU 1011
        expect_wr(8'h03, 8'h4B);
        do_req(4'd5, 3'd0, 3'd0, 4'b1011, 1'b0, 8'h00);
        idle(2);

        // Sweep all legal classes
        exp_addr = 8'h04;
        for (int i = 0; i < 13; i++) begin
            expect_wr(exp_addr, enc(i[3:0], 3'(i % 8), 3'((i + 3) % 8), 4'(15 - i)));
            exp_addr = exp_addr + 8'd1;
            do_req(i[3:0], 3'(i % 8), 3'((i + 3) % 8), 4'(15 - i), 1'b0, 8'h00);
        end
        idle(3);
        chk("sweep_addr", {8'd0, mem_addr}, {8'd0, exp_addr});
        chk("sweep_drain", 16'(sb.size()), 16'd0);

        // Illegal class 14
`ifdef INSTR_ENCODER_CHECK_EN
        do_req(4'd14, 3'd1, 3'd1, 4'd0, 1'b0, 8'h00);
        idle(3);
        chk("illegal_error", {15'd0, error}, 16'd1);
`else
        expect_wr(exp_addr, 8'h00);
        exp_addr = exp_addr + 8'd1;
        do_req(4'd14, 3'd1, 3'd1, 4'd0, 1'b0, 8'h00);
        idle(3);
        chk("illegal_error", {15'd0, error}, 16'd0);
`endif
        chk("illegal_addr", {8'd0, mem_addr}, {8'd0, exp_addr});

        // Clear wins over a simultaneous request
        @(negedge clk);
        clear = 1'b1; req_valid = 1'b1; req_class = 4'd1;
        @(posedge clk);
        #1 clear = 1'b0; req_valid = 1'b0;
        idle(3);
        chk("clear_prio_addr", {8'd0, mem_addr}, 16'd0);

        // Fill all 256 addresses
        exp_addr = 8'h00;
        for (int i = 0; i < 256; i++) begin
            expect_wr(8'(i), 8'h00);
            do_req(4'd0, 3'd0, 3'd0, 4'd0, 1'b0, 8'h00);
        end
        idle(2);
        chk("full_flag", {15'd0, full}, 16'd1);
        chk("full_addr", {8'd0, mem_addr}, 16'h00FF);
        req_valid = 1'b1;
        idle(5);
        chk("full_ready", {15'd0, req_ready}, 16'd0);
        req_valid = 1'b0;
        chk("full_drain", 16'(sb.size()), 16'd0);
        pulse_clear();
        @(negedge clk);
        chk("clear_full", {15'd0, full}, 16'd0);
        chk("clear_addr", {8'd0, mem_addr}, 16'd0);
        expect_wr(8'h00, 8'h01);
        do_req(4'd1, 3'd0, 3'd0, 4'd0, 1'b0, 8'h00);
        idle(2);
        chk("clear_rewrite", 16'(sb.size()), 16'd0);

        // Immediate request whose opcode lands at 255
        do_reset();
        for (int i = 0; i < 255; i++) begin
            expect_wr(8'(i), 8'h00);
            do_req(4'd0, 3'd0, 3'd0, 4'd0, 1'b0, 8'h00);
        end
        expect_wr(8'hFF, 8'h0B);
        do_req(4'd6, 3'd0, 3'd3, 4'd0, 1'b1, 8'h77);
        idle(4);
        chk("edge_full", {15'd0, full}, 16'd1);
        chk("edge_error", {15'd0, error}, 16'd1);
        chk("edge_addr", {8'd0, mem_addr}, 16'h00FF);
        chk("edge_drain", 16'(sb.size()), 16'd0);

        // Reset during the immediate write
        do_reset();
        expect_wr(8'h00, 8'h0A);
        do_req(4'd6, 3'd0, 3'd2, 4'd0, 1'b1, 8'h5A);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_we",    {15'd0, mem_we}, 16'd0);
        chk("midrst_addr",  {8'd0, mem_addr}, 16'd0);
        chk("midrst_wdata", {8'd0, mem_wdata}, 16'd0);
        chk("midrst_full",  {15'd0, full}, 16'd0);
        chk("midrst_error", {15'd0, error}, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3);
        chk("midrst_drain", 16'(sb.size()), 16'd0);
        chk("midrst_ready", {15'd0, req_ready}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
